cache_fill_ctrl: RTL and testbench

//  Initiator side of the byte-addressable 16-bit memory interface (addr/data_in/enable/wr -> data_out).
//  On a cache miss, fetches one 16-byte block (8 words) from the pipelined memory.

---
 rtl/cache_pkg.sv | 17 +
 rtl/blk_word_cnt.sv | 37 +++
 rtl/cache_fill_ctrl.sv | 133 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and block geometry for the cache fill controller
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int DEF_WORDS_PER_BLOCK = 8;

    function automatic int blk_off_bits(input int wpb);
        return $clog2(2 * wpb);
    endfunction

    localparam int BLK_OFF_BITS = blk_off_bits(DEF_WORDS_PER_BLOCK);

endpackage

// File: rtl/blk_word_cnt.sv
// rtl/blk_word_cnt.sv - per-block word up-counter with clear and block-complete flag
module blk_word_cnt #(
    parameter int WPB = 8,
    parameter int CW  = $clog2(WPB) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          done
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == CW'(WPB));

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - block fill on miss and write-through store forwarding to pipelined memory
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [15:0]           st_data,
    output logic                  st_ack,
    output logic                  fsm_busy,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [15:0]           fill_data,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    input  logic                  mem_data_valid
);

    localparam int OFF = blk_off_bits(WORDS_PER_BLOCK);
    localparam int CW  = $clog2(WORDS_PER_BLOCK) + 1;

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         issue_cnt, rcv_cnt;
    logic                  issue_done, rcv_done;
    logic                  issue_inc, rcv_inc, rcv_last, cnt_clr;
    logic                  unused_bits;

    assign unused_bits = ^{miss_address[OFF-1:0], st_addr[0]};

    // Valids are only accepted inside a fill; anything past the last word is dropped.
    assign issue_inc = (state_q == FILL) && !issue_done;
    assign rcv_inc   = (state_q == FILL) && mem_data_valid && !rcv_done;
    assign rcv_last  = rcv_inc && (rcv_cnt == CW'(WORDS_PER_BLOCK - 1));
    assign cnt_clr   = (state_q == IDLE) || rcv_last;

    blk_word_cnt #(.WPB(WORDS_PER_BLOCK), .CW(CW)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (issue_inc),
        .count (issue_cnt),
        .done  (issue_done)
    );

    blk_word_cnt #(.WPB(WORDS_PER_BLOCK), .CW(CW)) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rcv_inc),
        .count (rcv_cnt),
        .done  (rcv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d  = {miss_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    state_d = FILL;
                end
            end
            FILL: begin
                if (rcv_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        st_ack           = 1'b0;
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
        mem_enable       = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_data_in      = '0;
        case (state_q)
            IDLE: begin
                // A pending miss takes priority; the store waits for the next idle cycle.
                if (rst_n && st_req && !miss_detected) begin
                    st_ack      = 1'b1;
                    mem_enable  = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = {st_addr[ADDR_WIDTH-1:1], 1'b0};
                    mem_data_in = st_data;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = base_q + (ADDR_WIDTH'(issue_cnt) << 1);
                end
                if (rcv_inc) begin
                    write_data_array = 1'b1;
                    fill_addr        = base_q + (ADDR_WIDTH'(rcv_cnt) << 1);
                    fill_data        = mem_data_out;
                    write_tag_array  = rcv_last;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - directed self-checking bench for cache_fill_ctrl
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        st_req;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ack;
    logic        fsm_busy;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .st_req           (st_req),
        .st_addr          (st_addr),
        .st_data          (st_data),
        .st_ack           (st_ack),
        .fsm_busy         (fsm_busy),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data),
        .mem_enable       (mem_enable),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_data_valid   (mem_data_valid)
    );

    // Pipelined memory, latency 4: a read issued in cycle k returns in cycle k+4.
    logic        req_v = 1'b0;
    logic [15:0] req_a = '0;
    logic [3:0]  pv = '0;
    logic [15:0] pa [4];
    logic        stray_v = 1'b0;

    always @(negedge clk) begin
        req_v = mem_enable && !mem_wr;
        req_a = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = req_v;
        pa[0] = req_a;
    end

    assign mem_data_valid = pv[3] | stray_v;
    assign mem_data_out   = pa[3] ^ 16'hA5A5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, fsm_busy, 0);
        check({tag, "_st_ack"}, st_ack, 0);
        check({tag, "_wda"}, write_data_array, 0);
        check({tag, "_wta"}, write_tag_array, 0);
        check({tag, "_mem_en"}, mem_enable, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_fill_addr"}, fill_addr, 0);
        check({tag, "_fill_data"}, fill_data, 0);
        check({tag, "_mem_din"}, mem_data_in, 0);
    endtask

    // Called at the negedge of the first FILL cycle; returns at the first IDLE cycle.
    task automatic do_fill(input logic [15:0] base);
        logic [15:0] fa;
        for (int c = 0; c < 12; c++) begin
            check("busy", fsm_busy, 1);
            check("st_ack_fill", st_ack, 0);
            check("mem_wr_fill", mem_wr, 0);
            check("mem_en", mem_enable, (c < 8));
            if (c < 8) check("mem_addr", mem_addr, base + 16'(2 * c));
            check("wda", write_data_array, (c >= 4));
            if (c >= 4) begin
                fa = base + 16'(2 * (c - 4));
                check("fill_addr", fill_addr, fa);
                check("fill_data", fill_data, fa ^ 16'hA5A5);
            end
            check("wta", write_tag_array, (c == 11));
            if (c == 11) miss_detected = 1'b0;
            tick();
        end
        check("busy_done", fsm_busy, 0);
    endtask

    initial begin
        int pulses;
        rst_n         = 1'b0;
        miss_detected = 1'b0;
        miss_address  = '0;
        st_req        = 1'b0;
        st_addr       = '0;
        st_data       = '0;
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: basic fill
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        #1 check("t1_idle_busy", fsm_busy, 0);
        tick();
        do_fill(16'h1230);

        // 2: store in idle
        st_req  = 1'b1;
        st_addr = 16'h0041;
        st_data = 16'hBEEF;
        #1;
        check("t2_ack", st_ack, 1);
        check("t2_en", mem_enable, 1);
        check("t2_wr", mem_wr, 1);
        check("t2_addr", mem_addr, 16'h0040);
        check("t2_din", mem_data_in, 16'hBEEF);
        check("t2_busy", fsm_busy, 0);
        tick();
        st_req = 1'b0;
        #1 check("t2_ack_drop", st_ack, 0);

        // 3: simultaneous miss and store
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        st_req        = 1'b1;
        st_addr       = 16'h0010;
        st_data       = 16'h1234;
        #1;
        check("t3_ack_held", st_ack, 0);
        check("t3_en_held", mem_enable, 0);
        tick();
        do_fill(16'h2000);
        check("t3_ack", st_ack, 1);
        check("t3_wr", mem_wr, 1);
        check("t3_addr", mem_addr, 16'h0010);
        check("t3_din", mem_data_in, 16'h1234);
        tick();
        st_req = 1'b0;
        #1 check("t3_ack_drop", st_ack, 0);

        // 4: top-of-memory block
        miss_detected = 1'b1;
        miss_address  = 16'hFFFE;
        tick();
        do_fill(16'hFFF0);

        // 5: reset after three returned words
        miss_detected = 1'b1;
        miss_address  = 16'h4008;
        tick();
        pulses = 0;
        for (int c = 0; c < 7; c++) begin
            if (write_data_array) pulses++;
            if (c < 6) tick();
        end
        check("t5_pre_pulses", pulses, 3);
        miss_detected = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_valid_live", mem_data_valid, 1);
        check_all_zero("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (write_data_array || write_tag_array || fsm_busy) pulses++;
        end
        check("t5_trailing_ignored", pulses, 0);

        // 6: stray valid in idle
        stray_v = 1'b1;
        #1;
        check("t6_wda", write_data_array, 0);
        check("t6_wta", write_tag_array, 0);
        tick();
        stray_v = 1'b0;
        check("t6_busy", fsm_busy, 0);
        check("t6_mem_en", mem_enable, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
